// File: rtl/burst_pkg.sv
// Shared types, default widths and address helper for the burst adapter slice.
package burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_REQ,
        RD_DATA,
        RESP
    } burst_state_t;

    localparam int DEFAULT_LINE_WIDTH = 256;
    localparam int DEFAULT_BEAT_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    // Clears the byte-offset bits so the address points at the start of a line.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned offs);
        return addr & ~((64'd1 << offs) - 64'd1);
    endfunction

endpackage

// File: rtl/line_assembler.sv
// Beat-indexed line register bank: whole-line load for writes, per-beat fill for reads.
module line_assembler
    import burst_pkg::*;
#(
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
    parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH,
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH,
    localparam int IDX_W = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LINE_WIDTH-1:0] line_in,
    input  logic                  beat_we,
    input  logic [IDX_W-1:0]      beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_in,
    input  logic [IDX_W-1:0]      sel_idx,
    output logic [BEAT_WIDTH-1:0] beat_out,
    output logic [LINE_WIDTH-1:0] fill_line
);

    logic [BEAT_WIDTH-1:0] bank [BEATS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++) bank[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < BEATS; i++) bank[i] <= line_in[i*BEAT_WIDTH +: BEAT_WIDTH];
        end else if (beat_we) begin
            bank[beat_idx] <= beat_in;
        end
    end

    assign beat_out = bank[sel_idx];

    // The completing beat bypasses the bank so the line is ready in the same edge.
    always_comb begin
        fill_line = '0;
        for (int i = 0; i < BEATS - 1; i++) fill_line[i*BEAT_WIDTH +: BEAT_WIDTH] = bank[i];
        fill_line[(BEATS-1)*BEAT_WIDTH +: BEAT_WIDTH] = beat_in;
    end

endmodule

// File: rtl/burst_adapter.sv
// Bridge between the cache-line dfp port and the beat-serial bmem burst port.
module burst_adapter
    import burst_pkg::*;
#(
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
    parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFFS  = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    burst_state_t state, state_next;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic [BEAT_WIDTH-1:0] wr_beat;
    logic [LINE_WIDTH-1:0] fill_line;
    logic                  rd_capture;
    logic                  last_beat;

    assign aligned_addr = ADDR_WIDTH'(line_align(64'(dfp_addr), OFFS));
    assign last_beat    = (count == LAST);

    // A beat also counts in the cycle the read request is accepted.
    assign rd_capture = bmem_rvalid && (bmem_raddr == addr_q) &&
                        ((state == RD_DATA) || (state == RD_REQ && bmem_ready));

    line_assembler #(
        .LINE_WIDTH(LINE_WIDTH),
        .BEAT_WIDTH(BEAT_WIDTH)
    ) u_line (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE && dfp_write),
        .line_in  (dfp_wdata),
        .beat_we  (rd_capture),
        .beat_idx (count),
        .beat_in  (bmem_rdata),
        .sel_idx  (count),
        .beat_out (wr_beat),
        .fill_line(fill_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dfp_write)     state_next = WR_BURST;
                else if (dfp_read) state_next = RD_REQ;
            end
            WR_BURST: if (bmem_ready && last_beat) state_next = RESP;
            RD_REQ:   if (bmem_ready) state_next = RD_DATA;
            RD_DATA:  if (rd_capture && last_beat) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Beat counter, latched line address and the completed read line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            addr_q    <= '0;
            dfp_rdata <= '0;
        end else begin
            case (state)
                IDLE:     count <= '0;
                WR_BURST: if (bmem_ready) count <= count + CNT_W'(1);
                RD_REQ, RD_DATA: if (rd_capture) count <= count + CNT_W'(1);
                default:  count <= '0;
            endcase
            if (state == IDLE && (dfp_write || dfp_read)) addr_q <= aligned_addr;
            if (state == RD_DATA && rd_capture && last_beat) dfp_rdata <= fill_line;
        end
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        bmem_addr  = '0;
        dfp_resp   = 1'b0;
        case (state)
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_wdata = wr_beat;
                bmem_addr  = addr_q;
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
            end
            RESP:    dfp_resp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_burst_adapter.sv
// Directed and randomized checks of burst_adapter against a cycle-level behavioural model.
module tb_burst_adapter;

    localparam int LW    = 256;
    localparam int BW    = 64;
    localparam int AW    = 32;
    localparam int BEATS = LW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] dfp_addr;
    logic          dfp_read;
    logic          dfp_write;
    logic [LW-1:0] dfp_wdata;
    logic [LW-1:0] dfp_rdata;
    logic          dfp_resp;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic          bmem_ready;
    logic [AW-1:0] bmem_raddr;
    logic [BW-1:0] bmem_rdata;
    logic          bmem_rvalid;

    int compared   = 0;
    int mismatched = 0;
    logic [LW-1:0] last_rd_line;

    burst_adapter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] beatOf(input logic [LW-1:0] line, input int i);
        return line[i*BW +: BW];
    endfunction

    function automatic logic [LW-1:0] randLine();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rdata"}, dfp_rdata, '0);
        checkOutput({tag, "_resp"}, LW'(dfp_resp), '0);
        checkOutput({tag, "_baddr"}, LW'(bmem_addr), '0);
        checkOutput({tag, "_bread"}, LW'(bmem_read), '0);
        checkOutput({tag, "_bwrite"}, LW'(bmem_write), '0);
        checkOutput({tag, "_bwdata"}, LW'(bmem_wdata), '0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_idle_resp"}, LW'(dfp_resp), '0);
        checkOutput({tag, "_idle_bread"}, LW'(bmem_read), '0);
        checkOutput({tag, "_idle_bwrite"}, LW'(bmem_write), '0);
        checkOutput({tag, "_idle_baddr"}, LW'(bmem_addr), '0);
    endtask

    // Model: one beat leaves per ready cycle, in slice order; resp follows the last one.
    task automatic applyStimulusWrite(input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                                      input logic [63:0] low_mask, input bit both, input bit noise);
        logic [AW-1:0] aligned;
        int  sent;
        bit  done;
        aligned = addr & ~32'h1F;
        sent = 0;
        done = 1'b0;
        dfp_addr = addr; dfp_wdata = wdata; dfp_write = 1'b1; dfp_read = both;
        bmem_rvalid = 1'b0;
        @(negedge clk);
        checkIdle("wr");
        tick();
        for (int k = 1; k < 64 && !done; k++) begin
            if (noise && sent < BEATS) begin
                dfp_write = 1'($urandom); dfp_read = 1'($urandom);
                dfp_addr = $urandom; dfp_wdata = randLine();
                bmem_rvalid = 1'($urandom); bmem_raddr = aligned; bmem_rdata = {$urandom, $urandom};
            end else begin
                dfp_write = 1'b0; dfp_read = 1'b0; bmem_rvalid = 1'b0;
            end
            bmem_ready = ~low_mask[k];
            @(negedge clk);
            if (sent < BEATS) begin
                checkOutput("wr_valid", LW'(bmem_write), LW'(1'b1));
                checkOutput("wr_beat", LW'(bmem_wdata), LW'(beatOf(wdata, sent)));
                checkOutput("wr_addr", LW'(bmem_addr), LW'(aligned));
                checkOutput("wr_no_resp", LW'(dfp_resp), '0);
            end else begin
                checkOutput("wr_resp", LW'(dfp_resp), LW'(1'b1));
                checkOutput("wr_resp_bwrite", LW'(bmem_write), '0);
                checkOutput("wr_resp_baddr", LW'(bmem_addr), '0);
                done = 1'b1;
            end
            checkOutput("wr_no_bread", LW'(bmem_read), '0);
            checkOutput("wr_rdata_hold", dfp_rdata, last_rd_line);
            if (bmem_ready && sent < BEATS) sent++;
            tick();
        end
    endtask

    // Model phases: 0 = request outstanding, 1 = collecting beats, 2 = response cycle.
    task automatic applyStimulusRead(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                                     input int ready_delay, input bit stray, input bit gaps,
                                     input bit same_cycle, input int abort_after, input bit noise);
        logic [AW-1:0] aligned;
        int  phase;
        int  got;
        bit  real_beat;
        bit  done;
        aligned = addr & ~32'h1F;
        phase = 0;
        got = 0;
        done = 1'b0;
        dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0;
        bmem_rvalid = 1'b0;
        @(negedge clk);
        checkIdle("rd");
        tick();
        for (int k = 1; k < 200 && !done; k++) begin
            if (noise && phase != 2) begin
                dfp_write = 1'($urandom); dfp_read = 1'($urandom);
                dfp_addr = $urandom; dfp_wdata = randLine();
            end else begin
                dfp_write = 1'b0; dfp_read = 1'b0;
            end
            bmem_ready = (phase == 0) ? (k > ready_delay) : 1'($urandom);
            real_beat = 1'b0;
            if (phase == 1 && got < BEATS) real_beat = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (phase == 0 && bmem_ready) real_beat = same_cycle;
            if (real_beat) begin
                bmem_rvalid = 1'b1; bmem_raddr = aligned; bmem_rdata = beatOf(line, got);
            end else if (stray && phase != 2 && $urandom_range(0, 1) == 1) begin
                bmem_rvalid = 1'b1; bmem_raddr = aligned ^ 32'hC0; bmem_rdata = {$urandom, $urandom};
            end else begin
                bmem_rvalid = 1'b0; bmem_raddr = aligned; bmem_rdata = {$urandom, $urandom};
            end
            @(negedge clk);
            checkOutput("rd_bread", LW'(bmem_read), LW'(phase == 0));
            checkOutput("rd_baddr", LW'(bmem_addr), (phase == 0) ? LW'(aligned) : '0);
            checkOutput("rd_resp", LW'(dfp_resp), LW'(phase == 2));
            checkOutput("rd_bwrite", LW'(bmem_write), '0);
            checkOutput("rd_rdata", dfp_rdata, (phase == 2) ? line : last_rd_line);
            if (phase == 2) begin
                done = 1'b1;
                last_rd_line = line;
            end else begin
                if (phase == 0 && bmem_ready) phase = 1;
                if (real_beat) got++;
                if (got == BEATS) phase = 2;
            end
            tick();
            if (abort_after > 0 && got == abort_after && phase == 1) return;
        end
    endtask

    initial begin
        logic [LW-1:0] line;
        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        last_rd_line = '0;
        #2;
        checkReset("por");
        tick();
        tick();
        rst = 1'b0;

        line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        applyStimulusWrite(32'h0000_1024, line, 64'h0, 1'b0, 1'b0);
        applyStimulusWrite(32'h0000_1024, line, 64'hC, 1'b0, 1'b0);

        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        applyStimulusRead(32'h40, line, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulusRead(32'h40, ~line, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        applyStimulusWrite(32'h0000_2000, randLine(), 64'h0, 1'b1, 1'b0);
        applyStimulusRead(32'h0000_3F7F, randLine(), 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Abort a read after two beats, then confirm nothing leaks into a fresh read.
        applyStimulusRead(32'h40, line, 1, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        rst = 1'b1;
        bmem_rvalid = 1'b1; bmem_raddr = 32'h40; bmem_rdata = {$urandom, $urandom};
        #1;
        checkReset("abort");
        @(negedge clk);
        checkReset("abort_hold");
        tick();
        rst = 1'b0;
        last_rd_line = '0;
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h40; bmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("post_abort_resp", LW'(dfp_resp), '0);
            checkOutput("post_abort_rdata", dfp_rdata, '0);
            tick();
        end
        bmem_rvalid = 1'b0;
        applyStimulusRead(32'h100, randLine(), 2, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1)
                applyStimulusWrite($urandom, randLine(), {48'h0, 16'($urandom)}, 1'($urandom), 1'b1);
            else
                applyStimulusRead($urandom, randLine(), $urandom_range(0, 5), 1'($urandom),
                                  1'($urandom), 1'($urandom), 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/burst_adapter.md
Name: burst_adapter

Overview:
- Parametrised bridge between the cache-line port (dfp_*) and the beat-serial burst memory port (bmem_*).
- Splits one LINE_WIDTH write into BEATS bmem beats.
- Issues one bmem read per line and assembles the BEATS returned beats into a line.
- Sits between the L1 cache arbiter and the memory model. Handles reads and writes in one FSM, with address matching and back-pressure.

Parameters:
- LINE_WIDTH, 256, cache-line width in bits.
- BEAT_WIDTH, 64, bmem data width in bits. LINE_WIDTH/BEAT_WIDTH must be a power of two and at least 2.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dfp_addr  in  ADDR_WIDTH  line request address.
- dfp_read  in  1  line read request.
- dfp_write  in  1  line write request.
- dfp_wdata  in  LINE_WIDTH  write line.
- dfp_rdata  out  LINE_WIDTH  assembled read line.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  ADDR_WIDTH  burst address, line-aligned.
- bmem_read  out  1  read burst request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_WIDTH  write beat.
- bmem_ready  in  1  bmem accepts the request/beat this cycle.
- bmem_raddr  in  ADDR_WIDTH  address tag of the returning beat.
- bmem_rdata  in  BEAT_WIDTH  returning beat.
- bmem_rvalid  in  1  returning beat valid.

Behaviour:
- Derived constants:
  - BEATS = LINE_WIDTH/BEAT_WIDTH.
  - Beat counter width is $clog2(BEATS).
  - OFFS = $clog2(LINE_WIDTH/8).
- Reset (async, rst=1): state IDLE, counter 0, latched address/line 0. All outputs 0, including dfp_rdata and dfp_resp.
- Reset mid-burst: partial data is discarded and no dfp_resp is issued. Beats arriving afterwards in IDLE are dropped.
- FSM states: IDLE, WR_BURST, RD_REQ, RD_DATA, RESP.
- IDLE:
  - dfp_write=1: latch dfp_addr with the low OFFS bits cleared, latch dfp_wdata, go to WR_BURST, count=0.
  - Else dfp_read=1: latch the aligned address, go to RD_REQ.
  - Both asserted: write wins.
  - dfp inputs are ignored in every state other than IDLE.
- WR_BURST:
  - bmem_write=1, bmem_addr = latched address, bmem_wdata = latched line slice [count*BEAT_WIDTH +: BEAT_WIDTH].
  - Count increments only when bmem_ready=1. The beat is held while ready=0.
  - Beat BEATS-1 accepted: go to RESP.
- RD_REQ:
  - bmem_read=1 and bmem_addr is driven until bmem_ready=1 (exactly one accepted request).
  - Then go to RD_DATA, count=0.
  - A beat arriving in the same cycle as acceptance is captured as beat 0.
- RD_DATA:
  - Beats are accepted only when bmem_rvalid=1 and bmem_raddr equals the latched address. Mismatched beats are ignored.
  - Beat i is stored into slice i. Beats are in order.
  - Last beat: dfp_rdata <= {last beat, stored slices}, go to RESP.
- RESP:
  - dfp_resp=1 for exactly one cycle, then IDLE.
  - dfp_rdata holds its value until the next read completes. It is unchanged by writes.
- Latency:
  - Write: dfp_resp is asserted BEATS+1 cycles after acceptance, with no stalls.
  - Read: dfp_resp is asserted 1 cycle after the last valid beat.
- Idle defaults: bmem_read, bmem_write, bmem_wdata and bmem_addr are 0 outside their states. No combinational path from dfp_* to bmem_*.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after RESP.

Decomposition:
- Shared package burst_pkg:
  - burst_state_t enum (IDLE, WR_BURST, RD_REQ, RD_DATA, RESP).
  - Default LINE_WIDTH/BEAT_WIDTH constants.
  - Function line_align(addr).
- One sub-module, line_assembler:
  - Beat-indexed register bank with load/select.
  - Used for the read fill and for write beat selection.

Test Plan:
- Write, ready always 1: addr 0x0000_1024, wdata beats {D,C,B,A} with A in bits [63:0] -> bmem_addr = 0x0000_1020; bmem_wdata A,B,C,D on consecutive cycles; dfp_resp on cycle 5.
- Write with ready stalls: ready low on cycles 2–3 -> beat B held two extra cycles; no beat duplicated or skipped; dfp_resp delayed by 2 cycles.
- Read: addr 0x40, ready after 3 cycles; rvalid beats 0x11..,0x22..,0x33..,0x44.. with raddr 0x40 -> single accepted bmem_read; dfp_rdata = {0x44..,0x33..,0x22..,0x11..}; dfp_resp one cycle after the last beat.
- Stray beats: rvalid with raddr 0x80 interleaved into a read of 0x40 -> stray beats ignored; line correct.
- Simultaneous dfp_read=dfp_write=1 in IDLE -> write burst performed; no bmem_read.
- Async rst asserted after 2 read beats, then a fresh read of 0x100 -> no dfp_resp for the aborted read; outputs 0 during reset; new line assembled correctly from beat 0.
